banked_spfifo: RTL and testbench

Synchronous FIFO built from BANKS interleaved single-port RAM banks, each holding DEPTH/BANKS words, so one push and one pop complete in the same cycle whenever they address different banks. Successor to the two-bank single-port FIFO, with these additions:
- bank count generalised to any power of two;
- explicit ready/ack handshake that arbitrates same-bank collisions;
- one-cycle registered read with rvalid;
- occupancy count output, sticky overflow/underflow flags, and a synchronous flush.

Used as the standard buffering stage wherever dual-port RAM is unavailable.

---
 rtl/banked_spfifo.sv | 114 +++++++++++
 tb/tb_banked_spfifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/banked_spfifo.sv
// banked_spfifo: synchronous FIFO built from BANKS interleaved single-port RAM
// banks. A push and a pop complete together whenever they target different
// banks; on a same-bank collision the write wins and the pop is refused.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous flush (pointers, rvalid, ovf/unf)
//   push, wdata         write request and data; accepted when push && push_rdy
//   push_rdy            write can be accepted this cycle
//   pop, pop_rdy        read request; accepted when pop && pop_rdy
//   rdata, rvalid       read data, valid the cycle after an accepted pop
//   count               current occupancy
//   full, empty         occupancy limits
//   al_full, al_empty   threshold flags
//   ovf, unf            sticky overflow / underflow flags
module banked_spfifo #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned BANKS       = 2,
  parameter int unsigned AL_FULL_TH  = 2,
  parameter int unsigned AL_EMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     push_rdy,
  input  logic                     pop,
  output logic                     pop_rdy,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     al_full,
  output logic                     al_empty,
  output logic                     ovf,
  output logic                     unf
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned BW  = $clog2(BANKS);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned BD  = DEPTH / BANKS;
  localparam int unsigned BAW = AW - BW;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    free_cnt;
  logic [BW-1:0]    wr_bank, rd_bank;
  logic [BAW-1:0]   wr_addr, rd_addr;
  logic             push_acc, pop_acc, collision;
  logic [WIDTH-1:0] bank_rd [BANKS];

  // Pointer decode: low bits select the bank, the rest address within it.
  assign wr_bank = wr_ptr[BW-1:0];
  assign rd_bank = rd_ptr[BW-1:0];
  assign wr_addr = wr_ptr[AW-1:BW];
  assign rd_addr = rd_ptr[AW-1:BW];

  // Status flags from the registered pointers.
  assign count    = wr_ptr - rd_ptr;
  assign free_cnt = PW'(DEPTH) - count;
  assign full     = (count == PW'(DEPTH));
  assign empty    = (count == '0);
  assign al_full  = (32'(free_cnt) <= AL_FULL_TH);
  assign al_empty = (32'(count) <= AL_EMPTY_TH);

  // Handshake: a write into the bank the read wants blocks the read.
  assign push_rdy  = !full && !clr;
  assign push_acc  = push && push_rdy;
  assign collision = push_acc && (rd_bank == wr_bank);
  assign pop_rdy   = !empty && !clr && !collision;
  assign pop_acc   = pop && pop_rdy;

  // Storage banks; the collision rule keeps each bank to one access per cycle.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] ram [BD];

    always_ff @(posedge clk) begin
      if (push_acc && (wr_bank == BW'(b))) ram[wr_addr] <= wdata;
    end

    assign bank_rd[b] = ram[rd_addr];
  end

  // Pointers, registered read port and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rvalid <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop_acc) begin
        rd_ptr <= rd_ptr + PW'(1);
        rdata  <= bank_rd[rd_bank];
      end
      rvalid <= pop_acc;
      if (push && full) ovf <= 1'b1;
      if (pop && empty) unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_banked_spfifo.sv
// tb_banked_spfifo: directed sequences plus randomized traffic against a
// queue-based reference model of banked_spfifo (DEPTH=16, BANKS=4).
module tb_banked_spfifo;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned BANKS = 4;
  localparam int unsigned AFT   = 2;
  localparam int unsigned AET   = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n, clr, push, pop;
  logic [WIDTH-1:0] wdata;
  logic             push_rdy, pop_rdy, rvalid;
  logic [WIDTH-1:0] rdata;
  logic [CW-1:0]    count;
  logic             full, empty, al_full, al_empty, ovf, unf;

  banked_spfifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BANKS(BANKS),
    .AL_FULL_TH(AFT), .AL_EMPTY_TH(AET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .push(push), .wdata(wdata), .push_rdy(push_rdy),
    .pop(pop), .pop_rdy(pop_rdy),
    .rdata(rdata), .rvalid(rvalid), .count(count),
    .full(full), .empty(empty), .al_full(al_full), .al_empty(al_empty),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: contents queue plus total push/pop counts for banking.
  logic [WIDTH-1:0] mq[$];
  int               wr_n, rd_n;
  bit               m_ovf, m_unf, m_rvalid;
  logic [WIDTH-1:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    wr_n     = 0;
    rd_n     = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  task automatic check_state();
    int n;
    n = mq.size();
    chk("count",    32'(count),    n);
    chk("full",     32'(full),     32'(n == DEPTH));
    chk("empty",    32'(empty),    32'(n == 0));
    chk("al_full",  32'(al_full),  32'((DEPTH - n) <= AFT));
    chk("al_empty", 32'(al_empty), 32'(n <= AET));
    chk("ovf",      32'(ovf),      32'(m_ovf));
    chk("unf",      32'(unf),      32'(m_unf));
    chk("rvalid",   32'(rvalid),   32'(m_rvalid));
    chk("rdata",    32'(rdata),    32'(m_rdata));
  endtask

  // One clock cycle: drive, check handshake, clock, update model, check state.
  task automatic step(input bit p, input bit q, input bit c, input logic [WIDTH-1:0] d);
    bit e_full, e_empty, e_prdy, e_qrdy, p_acc, q_acc;
    push = p; pop = q; clr = c; wdata = d;
    #1;
    e_full  = (mq.size() == DEPTH);
    e_empty = (mq.size() == 0);
    e_prdy  = !e_full && !c;
    p_acc   = p && e_prdy;
    e_qrdy  = !e_empty && !c && !(p_acc && ((wr_n % BANKS) == (rd_n % BANKS)));
    q_acc   = q && e_qrdy;
    chk("push_rdy", 32'(push_rdy), 32'(e_prdy));
    chk("pop_rdy",  32'(pop_rdy),  32'(e_qrdy));
    @(posedge clk);
    if (c) begin
      mq.delete();
      wr_n = 0; rd_n = 0;
      m_ovf = 1'b0; m_unf = 1'b0; m_rvalid = 1'b0;
    end else begin
      if (p && e_full)  m_ovf = 1'b1;
      if (q && e_empty) m_unf = 1'b1;
      m_rvalid = q_acc;
      if (q_acc) begin
        m_rdata = mq.pop_front();
        rd_n++;
      end
      if (p_acc) begin
        mq.push_back(d);
        wr_n++;
      end
    end
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr = 1'b0;
    check_state();
  endtask

  initial begin
    int bias;
    rst_n = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_state();
    chk("rst_push_rdy", 32'(push_rdy), 32'd1);
    chk("rst_pop_rdy",  32'(pop_rdy),  32'd0);

    // Fill to full, overflow attempt, drain, underflow attempt, flush.
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, WIDTH'(i));
    step(1, 0, 0, 16'hdead);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    step(1, 0, 0, 16'h0042);
    step(0, 0, 1, '0);

    // Same-bank collision at count == BANKS, then the held pop goes through.
    for (int i = 0; i < BANKS; i++) step(1, 0, 0, WIDTH'(16'h100 + i));
    step(1, 1, 0, 16'h0bad);
    step(0, 1, 0, '0);
    step(0, 0, 1, '0);

    // Steady push/pop pairs at count 1 across pointer wrap.
    step(1, 0, 0, 16'h0a00);
    for (int i = 0; i < 40; i++) step(1, 1, 0, WIDTH'($urandom));
    step(0, 0, 1, '0);

    // Reset during an accepted pop at count 5.
    for (int i = 0; i < 5; i++) step(1, 0, 0, WIDTH'(16'h200 + i));
    pop = 1'b1;
    #1;
    chk("mid_pop_rdy", 32'(pop_rdy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rvalid", 32'(rvalid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    pop = 1'b0;
    model_reset();
    check_state();
    rst_n = 1'b1;
    step(1, 0, 0, 16'h1234);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);

    // Randomized traffic with a slowly changing push/pop bias.
    bias = 2;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 150) == 0) bias = int'($urandom_range(0, 4));
      step(($urandom % 4) < bias, ($urandom % 4) < (4 - bias) + 0,
           ($urandom % 128) == 0, WIDTH'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
